mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shared-memory arbiter and sequencer for the pipelined RISC-V core. It sits between the instruction-cache refill path and the data-cache path, both requesters, and a single-port main memory with fixed read latency. It serialises accesses: one outstanding transaction at a time, round-robin arbitration, and registered grant and response pulses.

## Interface
Parameters:
- ADDR_W, 32, address width (byte address).
- DATA_W, 32, data word width.
- MEM_LAT, 2, cycles from the mem_en cycle to mem_rdata valid; must be ≥1, elaboration error otherwise.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  reset, asynchronous and active-low.
- i_req  in  1  instruction refill request (read-only), level.
- i_addr  in  ADDR_W  instruction address; held stable while i_req=1 and until i_gnt.
- i_gnt  out  1  one-cycle grant pulse for the instruction port.
- i_rvalid  out  1  one-cycle read-data-valid pulse.
- i_rdata  out  DATA_W  instruction read data; holds its value between reads.
- d_req  in  1  data request, level.
- d_we  in  1  1=write, 0=read; held stable with d_req.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  one-cycle grant pulse for the data port.
- d_rvalid  out  1  one-cycle completion pulse (read data valid, or write done).
- d_rdata  out  DATA_W  data read data; updated on reads only.
- mem_en  out  1  one-cycle access strobe to main memory.
- mem_we  out  1  write enable, held during BUSY.
- mem_addr  out  ADDR_W  address, held during BUSY.
- mem_wdata  out  DATA_W  write data, held during BUSY.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE:** requests are sampled here only.
  - If any req=1 at the edge, the arbiter picks an owner and latches owner, addr, we (i-port forces 0) and wdata. It loads cnt=MEM_LAT and moves to BUSY.
  - With no req, the FSM stays in IDLE.
- **BUSY:**
  - In the first cycle, the owner's gnt=1 and mem_en=1.
  - mem_we, mem_addr and mem_wdata are driven from the latch for every BUSY cycle.
  - cnt decrements each cycle. When cnt=0, the edge captures mem_rdata into the owner's rdata register (reads only) and the FSM moves to RESP.
- **RESP:**
  - The owner's rvalid=1 for one cycle.
  - d_rvalid also pulses for writes; in that case d_rdata is unchanged.
  - The FSM then returns to IDLE.
- **Arbitration:**
  - A single request wins outright.
  - When both requesters are active, the winner is the port that did not own the last granted transaction.
  - The last-owner bit resets to "instruction", so data wins the first tie.
  - The last-owner bit updates only on grant.
- **Requester rule:**
  - req must be deasserted the cycle after gnt unless a new transaction is intended.
  - A req still high when the FSM returns to IDLE is a new request.
  - A port never receives a second gnt before its rvalid.
- Addresses are passed through unmodified; memory indexes by word (addr>>2).
- **Reset (asserted low, any state):**
  - FSM goes to IDLE and last-owner goes to "instruction".
  - All outputs go to 0, including rdata registers, mem_addr and mem_wdata.
  - Any in-flight transaction is aborted with no rvalid.

## Timing
- Request sampled at edge of cycle c0 (IDLE): gnt and mem_en in c1; mem_rdata valid in c1+MEM_LAT; rvalid and rdata in c1+MEM_LAT+1.
- Request-to-rvalid latency is MEM_LAT+2 cycles.
- Next request is sampled in the IDLE cycle c1+MEM_LAT+2, giving a back-to-back throughput of one transaction per MEM_LAT+3 cycles.
- gnt, rvalid and mem_en are registered, glitch-free, and exactly one cycle wide.
- A req arriving during BUSY or RESP waits, with no loss; it is serviced at the next IDLE under the arbitration rule.
- Simultaneous i_req and d_req in IDLE are resolved by the arbitration rule; the loser keeps req high and is served next.

## Configuration
- `ARB_DPRIO_EN` defined: fixed priority. d_req always wins over i_req and the last-owner bit is unused; the instruction port can starve under continuous data traffic.
- Not defined (default): round-robin as in Operation.

## Test plan
- **Reset:**
  - Stimulus: reset=0 with i_req=1, then release.
  - Required: all outputs 0 while reset is low; first i_gnt one cycle after the first sampled edge.
- **Single read, MEM_LAT=2:**
  - Stimulus: i_req at c0, i_addr=0x10, memory word 4 = 0x00500093.
  - Required: i_gnt and mem_en in c1 with mem_addr=0x10; i_rvalid in c4 with i_rdata=0x00500093.
- **Data write:**
  - Stimulus: d_req, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF.
  - Required: mem_we=1 for 3 cycles with the latched values; d_rvalid in c4; d_rdata unchanged; subsequent read of 0x20 returns 0xDEADBEEF.
- **Tie after reset:**
  - Stimulus: i_req and d_req held high continuously.
  - Required: grant order D,I,D,I, with grants 5 cycles apart. With `ARB_DPRIO_EN`: D,D,D.
- **Mid-transaction reset:**
  - Stimulus: reset asserted in the second BUSY cycle of a read.
  - Required: mem_en, mem_we and all rvalid stay 0; FSM in IDLE; no response delivered after release.
- **MEM_LAT=1 build:**
  - Stimulus: single d read of 0x0 containing 0x7.
  - Required: d_rvalid exactly 3 cycles after the request edge; d_rdata=0x7.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: instruction port, data port and main-memory side.
// slave is the arbiter's view; master is the requester/memory environment.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction-refill and data accesses onto a single fixed-latency memory port.
// Define ARB_DPRIO_EN for fixed data-over-instruction priority; default is round-robin.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

  if (MEM_LAT < 1) begin : gLatCheck
    $error("mem_arbiter: MEM_LAT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] iRdata_q, iRdata_d;
  logic [DATA_W-1:0] dRdata_q, dRdata_d;
  logic              iGnt_q, iGnt_d;
  logic              dGnt_q, dGnt_d;
  logic              memEn_q, memEn_d;
  logic              iRvalid_q, iRvalid_d;
  logic              dRvalid_q, dRvalid_d;
  logic              pickData;

`ifdef ARB_DPRIO_EN
  assign pickData = bus.d_req;
`else
  owner_e lastOwner_q, lastOwner_d;

  // On a tie the port that did not own the previous grant wins.
  assign pickData = bus.d_req & (~bus.i_req | (lastOwner_q == OWN_I));
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    iRdata_d  = iRdata_q;
    dRdata_d  = dRdata_q;
    iGnt_d    = 1'b0;
    dGnt_d    = 1'b0;
    memEn_d   = 1'b0;
    iRvalid_d = 1'b0;
    dRvalid_d = 1'b0;
`ifndef ARB_DPRIO_EN
    lastOwner_d = lastOwner_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.i_req | bus.d_req) begin
          owner_d = pickData ? OWN_D : OWN_I;
          addr_d  = pickData ? bus.d_addr : bus.i_addr;
          we_d    = pickData & bus.d_we;
          wdata_d = bus.d_wdata;
          cnt_d   = CNT_W'(MEM_LAT);
          iGnt_d  = ~pickData;
          dGnt_d  = pickData;
          memEn_d = 1'b1;
`ifndef ARB_DPRIO_EN
          lastOwner_d = pickData ? OWN_D : OWN_I;
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          // Memory data is valid in this cycle; writes leave the rdata registers alone.
          if (!we_q) begin
            if (owner_q == OWN_D) dRdata_d = bus.mem_rdata;
            else                  iRdata_d = bus.mem_rdata;
          end
          iRvalid_d = (owner_q == OWN_I);
          dRvalid_d = (owner_q == OWN_D);
          we_d      = 1'b0;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      cnt_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      iRdata_q  <= '0;
      dRdata_q  <= '0;
      iGnt_q    <= 1'b0;
      dGnt_q    <= 1'b0;
      memEn_q   <= 1'b0;
      iRvalid_q <= 1'b0;
      dRvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      iRdata_q  <= iRdata_d;
      dRdata_q  <= dRdata_d;
      iGnt_q    <= iGnt_d;
      dGnt_q    <= dGnt_d;
      memEn_q   <= memEn_d;
      iRvalid_q <= iRvalid_d;
      dRvalid_q <= dRvalid_d;
    end
  end

`ifndef ARB_DPRIO_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lastOwner_q <= OWN_I;
    else        lastOwner_q <= lastOwner_d;
  end
`endif

  assign bus.i_gnt     = iGnt_q;
  assign bus.d_gnt     = dGnt_q;
  assign bus.i_rvalid  = iRvalid_q;
  assign bus.d_rvalid  = dRvalid_q;
  assign bus.i_rdata   = iRdata_q;
  assign bus.d_rdata   = dRdata_q;
  assign bus.mem_en    = memEn_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level model of arbitration order, latency and memory contents.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LAT    = 2;
`ifdef ARB_DPRIO_EN
  localparam bit DPRIO = 1'b1;
`else
  localparam bit DPRIO = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(LAT)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(1)) dutLat1 (
    .clock(clock), .reset(reset), .bus(bus1)
  );

  int checks = 0;
  int passes = 0;

  // Memory contents before any write; word 4 and word 0 hold the documented test values.
  function automatic logic [31:0] initWord(input logic [7:0] idx);
    if (idx == 8'd4) return 32'h0050_0093;
    if (idx == 8'd0) return 32'h0000_0007;
    return 32'hC0DE_0000 ^ {4{idx}};
  endfunction

  // Fixed-latency memory for the main DUT: data is valid only exactly LAT cycles after mem_en.
  logic [DATA_W-1:0] memArr [256];
  bit                memWritten [256];
  int                pendCnt = 0;
  logic [ADDR_W-1:0] pendAddr = '0;
  logic [7:0]        pIdx;
  always @(posedge clock) begin
    if (bus.mem_en) begin
      pendCnt  <= LAT;
      pendAddr <= bus.mem_addr;
      if (bus.mem_we) begin
        memArr[bus.mem_addr[9:2]]     <= bus.mem_wdata;
        memWritten[bus.mem_addr[9:2]] <= 1'b1;
      end
    end else if (pendCnt > 0) begin
      pendCnt <= pendCnt - 1;
    end
  end
  assign pIdx = pendAddr[9:2];
  assign bus.mem_rdata = (pendCnt == 1) ? (memWritten[pIdx] ? memArr[pIdx] : initWord(pIdx))
                                        : 32'hBAD0_0BAD;

  int                pend1Cnt = 0;
  logic [ADDR_W-1:0] pend1Addr = '0;
  always @(posedge clock) begin
    if (bus1.mem_en) begin
      pend1Cnt  <= 1;
      pend1Addr <= bus1.mem_addr;
    end else if (pend1Cnt > 0) begin
      pend1Cnt <= pend1Cnt - 1;
    end
  end
  assign bus1.mem_rdata = (pend1Cnt == 1) ? initWord(pend1Addr[9:2]) : 32'hBAD0_0BAD;

  // Reference model state
  logic [31:0] refMem [256];
  bit          mLastD;
  logic [31:0] mIRdata;
  logic [31:0] mDRdata;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    bus1.d_req = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    mLastD  = 1'b0;
    mIRdata = '0;
    mDRdata = '0;
  endtask

  task automatic test_reset();
    logic [133:0] outs;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h10;
    #2 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      outs = {bus.i_gnt, bus.i_rvalid, bus.i_rdata, bus.d_gnt, bus.d_rvalid, bus.d_rdata,
              bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata};
      checks++;
      if (outs !== '0) $display("[TB] FAIL reset_outputs cycle %0d: got %h expected 0", k, outs);
      else passes++;
    end
    reset = 1'b1;
    tick();
    checks++;
    if (bus.i_gnt !== 1'b1 || bus.d_gnt !== 1'b0 || bus.mem_addr !== 32'h10)
      $display("[TB] FAIL reset_first_gnt: i_gnt=%b d_gnt=%b mem_addr=%h expected 1 0 00000010",
               bus.i_gnt, bus.d_gnt, bus.mem_addr);
    else passes++;
    bus.i_req = 1'b0;
    for (int k = 0; k < LAT + 2; k++) tick();
  endtask

  task automatic test_single_read();
    int early;
    early = 0;
    do_reset();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h10;
    tick();
    checks++;
    if (bus.i_gnt !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_addr !== 32'h10 || bus.mem_we !== 1'b0)
      $display("[TB] FAIL read_gnt: i_gnt=%b mem_en=%b mem_addr=%h mem_we=%b expected 1 1 00000010 0",
               bus.i_gnt, bus.mem_en, bus.mem_addr, bus.mem_we);
    else passes++;
    bus.i_req = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      tick();
      if (bus.i_rvalid || bus.i_gnt || bus.mem_en) early++;
    end
    tick();
    checks++;
    if (early != 0 || bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'h0050_0093)
      $display("[TB] FAIL read_resp: early=%0d i_rvalid=%b i_rdata=%h expected 0 1 00500093",
               early, bus.i_rvalid, bus.i_rdata);
    else passes++;
    mIRdata = 32'h0050_0093;
    tick();
  endtask

  task automatic test_data_write();
    int weCycles;
    weCycles = 0;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h20;
    bus.d_wdata = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (bus.d_gnt !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_addr !== 32'h20 ||
        bus.mem_wdata !== 32'hDEAD_BEEF)
      $display("[TB] FAIL write_gnt: d_gnt=%b mem_en=%b mem_addr=%h mem_wdata=%h expected 1 1 00000020 deadbeef",
               bus.d_gnt, bus.mem_en, bus.mem_addr, bus.mem_wdata);
    else passes++;
    bus.d_req = 1'b0;
    bus.d_wdata = 32'h0;
    bus.d_addr  = 32'h0;
    for (int k = 0; k <= LAT + 1; k++) begin
      if (k > 0) tick();
      if (bus.mem_we === 1'b1 && bus.mem_addr === 32'h20 && bus.mem_wdata === 32'hDEAD_BEEF)
        weCycles++;
    end
    checks++;
    if (weCycles != LAT + 1)
      $display("[TB] FAIL write_we_cycles: got %0d expected %0d", weCycles, LAT + 1);
    else passes++;
    checks++;
    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== mDRdata)
      $display("[TB] FAIL write_resp: d_rvalid=%b d_rdata=%h expected 1 %h",
               bus.d_rvalid, bus.d_rdata, mDRdata);
    else passes++;
    refMem[8] = 32'hDEAD_BEEF;
    tick();
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h20;
    tick();
    checks++;
    if (bus.d_gnt !== 1'b1) $display("[TB] FAIL readback_gnt: d_gnt=%b expected 1", bus.d_gnt);
    else passes++;
    bus.d_req = 1'b0;
    for (int k = 0; k < LAT + 1; k++) tick();
    checks++;
    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== refMem[8])
      $display("[TB] FAIL readback_resp: d_rvalid=%b d_rdata=%h expected 1 %h",
               bus.d_rvalid, bus.d_rdata, refMem[8]);
    else passes++;
    mDRdata = refMem[8];
    tick();
  endtask

  task automatic test_tie();
    int waited;
    bit expD;
    do_reset();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h100;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h104;
    for (int g = 0; g < 4; g++) begin
      waited = 0;
      expD = DPRIO ? 1'b1 : (g % 2 == 0);
      do begin
        tick();
        waited++;
      end while (!(bus.i_gnt || bus.d_gnt) && waited < 20);
      checks++;
      if (bus.d_gnt !== expD || bus.i_gnt !== !expD || waited != (g == 0 ? 1 : LAT + 3))
        $display("[TB] FAIL tie_order grant %0d: d_gnt=%b i_gnt=%b gap=%0d expected d_gnt=%b gap=%0d",
                 g, bus.d_gnt, bus.i_gnt, waited, expD, (g == 0 ? 1 : LAT + 3));
      else passes++;
    end
    do_reset();
  endtask

  task automatic test_mid_reset();
    logic [133:0] outs;
    int activity;
    activity = 0;
    do_reset();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h40;
    tick();
    checks++;
    if (bus.i_gnt !== 1'b1) $display("[TB] FAIL midrst_gnt: i_gnt=%b expected 1", bus.i_gnt);
    else passes++;
    bus.i_req = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    outs = {bus.i_gnt, bus.i_rvalid, bus.i_rdata, bus.d_gnt, bus.d_rvalid, bus.d_rdata,
            bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata};
    checks++;
    if (outs !== '0) $display("[TB] FAIL midrst_outputs: got %h expected 0", outs);
    else passes++;
    tick();
    reset = 1'b1;
    for (int k = 0; k < LAT + 4; k++) begin
      tick();
      if (bus.mem_en || bus.mem_we || bus.i_rvalid || bus.d_rvalid || bus.i_gnt || bus.d_gnt ||
          bus.i_rdata !== '0)
        activity++;
    end
    checks++;
    if (activity != 0) $display("[TB] FAIL midrst_quiet: active cycles %0d expected 0", activity);
    else passes++;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h10;
    tick();
    checks++;
    if (bus.i_gnt !== 1'b1) $display("[TB] FAIL midrst_idle: i_gnt=%b expected 1", bus.i_gnt);
    else passes++;
    bus.i_req = 1'b0;
    for (int k = 0; k < LAT + 2; k++) tick();
  endtask

  task automatic test_random();
    int mode, n, waited, early;
    bit wantI, wantD, dWe, isD, w;
    logic [31:0] iA, dA, dWd, a;
    bit order [2];
    do_reset();
    for (int r = 0; r < 40; r++) begin
      mode  = $urandom_range(1, 3);
      wantI = (mode != 2);
      wantD = (mode != 1);
      iA    = ($urandom & 32'hFFFF_FC00) | ($urandom_range(0, 15) << 2);
      dA    = ($urandom & 32'hFFFF_FC00) | ($urandom_range(0, 15) << 2);
      dWe   = 1'($urandom_range(0, 1));
      dWd   = $urandom;
      if (wantI && wantD) begin
        order[0] = DPRIO ? 1'b1 : !mLastD;
        order[1] = !order[0];
        n = 2;
      end else begin
        order[0] = wantD;
        order[1] = 1'b0;
        n = 1;
      end
      bus.i_req   = wantI;
      bus.i_addr  = iA;
      bus.d_req   = wantD;
      bus.d_we    = dWe;
      bus.d_addr  = dA;
      bus.d_wdata = dWd;
      for (int t = 0; t < n; t++) begin
        isD = order[t];
        a   = isD ? dA : iA;
        w   = isD & dWe;
        waited = 0;
        early  = 0;
        do begin
          tick();
          waited++;
        end while (!(bus.i_gnt || bus.d_gnt) && waited < 20);
        checks++;
        if (waited != (t == 0 ? 1 : 2) || bus.d_gnt !== isD || bus.i_gnt !== !isD)
          $display("[TB] FAIL rnd_gnt round %0d txn %0d: d_gnt=%b i_gnt=%b wait=%0d expected d_gnt=%b wait=%0d",
                   r, t, bus.d_gnt, bus.i_gnt, waited, isD, (t == 0 ? 1 : 2));
        else passes++;
        checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== a || bus.mem_we !== w ||
            (w && bus.mem_wdata !== dWd))
          $display("[TB] FAIL rnd_mem round %0d: en=%b addr=%h we=%b wdata=%h expected 1 %h %b %h",
                   r, bus.mem_en, bus.mem_addr, bus.mem_we, bus.mem_wdata, a, w, dWd);
        else passes++;
        if (isD) bus.d_req = 1'b0;
        else     bus.i_req = 1'b0;
        mLastD = isD;
        for (int k = 0; k < LAT; k++) begin
          tick();
          if (bus.i_rvalid || bus.d_rvalid) early++;
        end
        tick();
        checks++;
        if (early != 0 || bus.d_rvalid !== isD || bus.i_rvalid !== !isD)
          $display("[TB] FAIL rnd_rvalid round %0d: early=%0d d_rvalid=%b i_rvalid=%b expected d_rvalid=%b",
                   r, early, bus.d_rvalid, bus.i_rvalid, isD);
        else passes++;
        if (w)        refMem[a[9:2]] = dWd;
        else if (isD) mDRdata = refMem[a[9:2]];
        else          mIRdata = refMem[a[9:2]];
        checks++;
        if (bus.i_rdata !== mIRdata || bus.d_rdata !== mDRdata)
          $display("[TB] FAIL rnd_rdata round %0d: i_rdata=%h d_rdata=%h expected %h %h",
                   r, bus.i_rdata, bus.d_rdata, mIRdata, mDRdata);
        else passes++;
      end
      tick();
    end
  endtask

  task automatic test_lat1();
    int waited, gntAt;
    waited = 0;
    gntAt  = 0;
    do_reset();
    bus1.d_req  = 1'b1;
    bus1.d_we   = 1'b0;
    bus1.d_addr = 32'h0;
    do begin
      tick();
      waited++;
      if (bus1.d_gnt) begin
        gntAt = waited;
        bus1.d_req = 1'b0;
      end
    end while (!bus1.d_rvalid && waited < 10);
    checks++;
    if (gntAt != 1 || waited != 3)
      $display("[TB] FAIL lat1_timing: gnt at %0d rvalid at %0d expected 1 and 3", gntAt, waited);
    else passes++;
    checks++;
    if (bus1.d_rdata !== 32'h7) $display("[TB] FAIL lat1_rdata: got %h expected 00000007", bus1.d_rdata);
    else passes++;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) refMem[i] = initWord(8'(i));
    bus.i_req = 1'b0;   bus.i_addr = '0;
    bus.d_req = 1'b0;   bus.d_we = 1'b0;  bus.d_addr = '0;  bus.d_wdata = '0;
    bus1.i_req = 1'b0;  bus1.i_addr = '0;
    bus1.d_req = 1'b0;  bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;
    mLastD = 1'b0;
    mIRdata = '0;
    mDRdata = '0;
    test_reset();
    test_single_read();
    test_data_write();
    test_tie();
    test_mid_reset();
    test_random();
    test_lat1();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d passed", passes, checks);
    $fatal(1, "[TB] timeout");
  end
endmodule
